stream_add_seq: RTL and testbench

STREAM_ADD_SEQ -- requirements
Module: stream_add_seq

---
 rtl/stream_add_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_stream_add_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_add_seq.sv
// -----------------------------------------------------------------------------
// stream_add_seq
//   Byte-serial adder. The block loads BYTES_IN operand bytes (x then y,
//   little-endian). It adds them one byte per cycle with a rippled carry, then
//   streams the BYTES_OUT result bytes out over a valid/ready handshake.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : operand byte
//   in_valid   : in_data valid
//   in_ready   : block accepts in_data (LOAD state)
//   out_data   : result byte (0 outside DRAIN)
//   out_valid  : out_data valid (DRAIN state)
//   out_ready  : consumer accepts out_data
//   carry_out  : final carry of the last addition, held until the next ADD
//   busy       : high while adding (ADD state)
//   abort      : synchronous return to LOAD, discards the transaction
// -----------------------------------------------------------------------------
module stream_add_seq #(
   parameter int unsigned LOG2_BYTES_IN  = 3,
   parameter int unsigned LOG2_BYTES_OUT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       carry_out,
   output logic       busy,
   input  logic       abort
);

   localparam int unsigned BYTES_IN  = 1 << LOG2_BYTES_IN;
   localparam int unsigned BYTES_OUT = 1 << LOG2_BYTES_OUT;
   localparam int unsigned CNT_W     = LOG2_BYTES_IN;
   localparam int unsigned RES_W     = LOG2_BYTES_OUT;

   localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(BYTES_IN - 1);
   localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(BYTES_OUT - 1);
   localparam logic [CNT_W-1:0] Y_BASE   = CNT_W'(BYTES_OUT);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ADD   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Control state
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             carry_q, carry_d;

   // Operand and result storage
   logic [7:0]       op_q  [BYTES_IN];
   logic [7:0]       op_d  [BYTES_IN];
   logic [7:0]       res_q [BYTES_OUT];
   logic [7:0]       res_d [BYTES_OUT];

   // Registered outputs
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q,      busy_d;
   logic [7:0]       out_data_q,  out_data_d;

   // Handshake events
   logic             in_xfer_c;
   logic             out_xfer_c;

   // Byte adder: x byte i + y byte i + carry, with i = counter during ADD
   logic [CNT_W-1:0] y_idx_c;
   logic [8:0]       sum_c;

   assign in_xfer_c  = in_valid  && (state_q == ST_LOAD);
   assign out_xfer_c = out_ready && (state_q == ST_DRAIN);

   assign y_idx_c = cnt_q + Y_BASE;
   assign sum_c   = {1'b0, op_q[cnt_q]} + {1'b0, op_q[y_idx_c]} + {8'd0, carry_q};

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and byte counter; abort overrides every transfer
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (abort) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (in_xfer_c) begin
                  if (cnt_q == LAST_IN) begin
                     state_d = ST_ADD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_ADD: begin
               if (cnt_q == LAST_OUT) begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (out_xfer_c) begin
                  if (cnt_q == LAST_OUT) begin
                     state_d = ST_LOAD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath next values: operand capture, byte add, carry ripple.
   // Abort clears only the carry; operand and result storage are kept.
   // ---------------------------------------------------------------------------
   always_comb begin
      op_d    = op_q;
      res_d   = res_q;
      carry_d = carry_q;
      if (abort) begin
         carry_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (in_xfer_c) begin
                  op_d[cnt_q] = in_data;
                  if (cnt_q == LAST_IN) begin
                     carry_d = 1'b0;
                  end
               end
            end
            ST_ADD: begin
               res_d[cnt_q[RES_W-1:0]] = sum_c[7:0];
               carry_d                 = sum_c[8];
            end
            default: begin
               carry_d = carry_q;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
         for (int unsigned i = 0; i < BYTES_IN; i++) begin
            op_q[i] <= '0;
         end
         for (int unsigned i = 0; i < BYTES_OUT; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         carry_q <= carry_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode from next state, so the outputs are registered yet still
   // track the state they describe in the same cycle
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready_d  = (state_d == ST_LOAD);
      out_valid_d = (state_d == ST_DRAIN);
      busy_d      = (state_d == ST_ADD);
      out_data_d  = '0;
      if (state_d == ST_DRAIN) begin
         out_data_d = res_d[cnt_d[RES_W-1:0]];
      end
   end

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_data_q  <= '0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = out_data_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_stream_add_seq.sv
// -----------------------------------------------------------------------------
// tb_stream_add_seq
//   Scoreboard bench for stream_add_seq. Stimulus pushes the expected result
//   bytes (from a plain 32-bit add) into a queue; a monitor pops and compares
//   on every output handshake.
// -----------------------------------------------------------------------------
module tb_stream_add_seq;

   localparam int BI = 8;
   localparam int BO = 4;

   typedef struct {
      logic [7:0] data;
      logic       carry;
   } exp_t;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic [7:0] in_data   = 8'h00;
   logic       in_valid  = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       carry_out;
   logic       busy;
   logic       abort     = 1'b0;

   int   tests = 0;
   int   fails = 0;
   exp_t expq[$];
   int   out_idx    = 0;
   bit   bp_random  = 1'b0;
   bit   gaps       = 1'b0;
   bit   stall_req  = 1'b0;
   int   stall_left = 0;

   stream_add_seq #(
      .LOG2_BYTES_IN  (3),
      .LOG2_BYTES_OUT (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .carry_out (carry_out),
      .busy      (busy),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: result = (x + y) mod 2^32, carry = bit 32
   task automatic push_expected(input logic [7:0] b [BI]);
      logic [31:0] x;
      logic [31:0] y;
      logic [32:0] s;
      exp_t        e;
      for (int k = 0; k < BO; k++) begin
         x[8*k +: 8] = b[k];
         y[8*k +: 8] = b[BO + k];
      end
      s = {1'b0, x} + {1'b0, y};
      for (int k = 0; k < BO; k++) begin
         e.data  = s[8*k +: 8];
         e.carry = s[32];
         expq.push_back(e);
      end
   endtask

   // Drive one byte; returns just after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (gaps && ($urandom_range(0, 3) == 0)) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_txn(input logic [7:0] b [BI], input bit push, input bit lat_chk);
      int n = 0;
      for (int k = 0; k < BI; k++) send_byte(b[k]);
      if (push) push_expected(b);
      if (lat_chk) begin
         for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) n++;
         end
         chk("add_cycles", 32'(n), 32'(BO));
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (expq.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(expq.size()), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after", 32'(in_ready), 32'd1);
   endtask

   // Monitor: output handshake scoreboard, back-pressure and state invariants
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("onehot_state", 32'($onehot({in_ready, busy, out_valid})), 32'd1);
            if (!out_valid) chk("out_data_idle", 32'(out_data), 32'd0);
            if (stall_req && out_valid && out_idx == 1) begin
               stall_req  = 1'b0;
               stall_left = 10;
            end
            if (stall_left > 0) begin
               stall_left--;
               out_ready = 1'b0;
               chk("stall_valid", 32'(out_valid), 32'd1);
               if (expq.size() > 0) chk("stall_hold", 32'(out_data), 32'(expq[0].data));
            end else if (bp_random) begin
               out_ready = ($urandom_range(0, 2) != 0);
            end else begin
               out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
               if (expq.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_out: got byte %0h, expected none", out_data);
               end else begin
                  e = expq.pop_front();
                  chk("out_data", 32'(out_data), 32'(e.data));
                  chk("carry_out", 32'(carry_out), 32'(e.carry));
                  out_idx = (out_idx + 1) % BO;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [7:0] v030 [BI];
      logic [7:0] v031 [BI];
      logic [7:0] v032 [BI];
      logic [7:0] vr   [BI];
      int         sel;

      v030 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      v031 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
      v032 = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_carry",     32'(carry_out), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic add with ADD-phase length
      send_txn(v030, 1'b1, 1'b1);
      wait_drain();

      // Full overflow to carry_out; carry held afterwards
      send_txn(v031, 1'b1, 1'b1);
      wait_drain();
      chk("carry_held", 32'(carry_out), 32'd1);

      // Inter-byte carry
      send_txn(v032, 1'b1, 1'b0);
      wait_drain();

      // Back-pressure held for 10 cycles on result byte 1
      stall_req = 1'b1;
      send_txn(v030, 1'b1, 1'b0);
      wait_drain();

      // Abort after 3 bytes, with a byte offered on the abort edge
      for (int k = 0; k < 3; k++) send_byte(8'($urandom));
      @(negedge clk);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(posedge clk);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      send_txn(v031, 1'b1, 1'b0);
      wait_drain();

      // Abort during ADD discards the transaction and clears carry
      send_txn(v031, 1'b0, 1'b0);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_add_ready", 32'(in_ready),  32'd1);
      chk("abort_add_busy",  32'(busy),      32'd0);
      chk("abort_add_carry", 32'(carry_out), 32'd0);
      send_txn(v030, 1'b1, 1'b0);
      wait_drain();

      // Asynchronous reset during the second ADD cycle
      send_txn(v031, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy",      32'(busy),      32'd0);
      chk("mid_rst_carry",     32'(carry_out), 32'd0);
      chk("mid_rst_out_data",  32'(out_data),  32'd0);
      out_idx = 0;
      @(negedge clk);
      rst_n = 1'b1;
      send_txn(v030, 1'b1, 1'b1);
      wait_drain();

      // Randomized traffic with input gaps and output back-pressure
      gaps      = 1'b1;
      bp_random = 1'b1;
      for (int t = 0; t < 30; t++) begin
         for (int k = 0; k < BI; k++) begin
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      vr[k] = 8'hFF;
            else if (sel == 1) vr[k] = 8'h00;
            else               vr[k] = 8'($urandom);
         end
         send_txn(vr, 1'b1, 1'b0);
         if ((t % 5) == 4) wait_drain();
      end
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
